// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, programmable almost flags,
// read-valid strobe, sticky error flags and a synchronous flush.
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              rd,
    output logic [WIDTH-1:0]  data_out,
    output logic              rd_valid,
    input  logic              clear,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_acc, wr_acc, mem_we;

    // Pointers carry one extra wrap bit so full and empty stay distinct.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    assign data_out  = data_out_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    always_comb begin
        rd_acc      = rd & ~empty;
        wr_acc      = wr & (~full | rd_acc);
        mem_we      = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        data_out_d  = data_out_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q | (wr & ~wr_acc);
        underflow_d = underflow_q | (rd & empty);
        if (clear) begin
            // Flush wins: requests in this cycle are dropped, data_out holds.
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                data_out_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
                rd_ptr_d   = rd_ptr_q + 1'b1;
                rd_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_in;
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a vector table plus hand-written
// sequences for fill/drain, overflow, streaming wrap and async reset.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr = 1'b0, rd = 1'b0, clear = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       rd_valid, full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    sync_fifo_param #(.WIDTH(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd),
        .data_out(data_out), .rd_valid(rd_valid), .clear(clear),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr, rd, clr;
        logic [7:0] din;
        logic [4:0] cnt;
        logic       emp, ful, ae, af;
        logic [7:0] dout;
        logic       rv, ovf, udf;
    } vec_t;

    vec_t vec [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock with the given request inputs; outputs are sampled 1ns after the edge.
    task automatic cyc(input logic w, input logic r, input logic c, input logic [7:0] d);
        wr = w; rd = r; clear = c; data_in = d;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; clear = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        vec[0]  = '{1'b0,1'b1,1'b0,8'h00, 5'd0,1'b1,1'b0,1'b1,1'b0, 8'h00,1'b0,1'b0,1'b1};
        vec[1]  = '{1'b1,1'b1,1'b0,8'hA5, 5'd1,1'b0,1'b0,1'b1,1'b0, 8'h00,1'b0,1'b0,1'b1};
        vec[2]  = '{1'b0,1'b1,1'b0,8'h00, 5'd0,1'b1,1'b0,1'b1,1'b0, 8'hA5,1'b1,1'b0,1'b1};
        vec[3]  = '{1'b0,1'b0,1'b0,8'h00, 5'd0,1'b1,1'b0,1'b1,1'b0, 8'hA5,1'b0,1'b0,1'b1};
        vec[4]  = '{1'b1,1'b0,1'b0,8'h01, 5'd1,1'b0,1'b0,1'b1,1'b0, 8'hA5,1'b0,1'b0,1'b1};
        vec[5]  = '{1'b1,1'b0,1'b0,8'h02, 5'd2,1'b0,1'b0,1'b1,1'b0, 8'hA5,1'b0,1'b0,1'b1};
        vec[6]  = '{1'b1,1'b0,1'b0,8'h03, 5'd3,1'b0,1'b0,1'b0,1'b0, 8'hA5,1'b0,1'b0,1'b1};
        vec[7]  = '{1'b1,1'b0,1'b0,8'h04, 5'd4,1'b0,1'b0,1'b0,1'b0, 8'hA5,1'b0,1'b0,1'b1};
        vec[8]  = '{1'b1,1'b0,1'b0,8'h05, 5'd5,1'b0,1'b0,1'b0,1'b0, 8'hA5,1'b0,1'b0,1'b1};
        vec[9]  = '{1'b1,1'b0,1'b1,8'h77, 5'd0,1'b1,1'b0,1'b1,1'b0, 8'hA5,1'b0,1'b0,1'b0};
        vec[10] = '{1'b1,1'b0,1'b0,8'h3C, 5'd1,1'b0,1'b0,1'b1,1'b0, 8'hA5,1'b0,1'b0,1'b0};
        vec[11] = '{1'b0,1'b1,1'b0,8'h00, 5'd0,1'b1,1'b0,1'b1,1'b0, 8'h3C,1'b1,1'b0,1'b0};
        vec[12] = '{1'b0,1'b0,1'b0,8'h00, 5'd0,1'b1,1'b0,1'b1,1'b0, 8'h3C,1'b0,1'b0,1'b0};

        do_reset();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ae", 32'(almost_empty), 32'd1);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        check("rst_rv", 32'(rd_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_udf", 32'(underflow), 32'd0);

        // Table: underflow, empty rd+wr, clear with concurrent write, post-clear use.
        for (int i = 0; i < 13; i++) begin
            cyc(vec[i].wr, vec[i].rd, vec[i].clr, vec[i].din);
            check($sformatf("v%0d_count", i), 32'(count), 32'(vec[i].cnt));
            check($sformatf("v%0d_empty", i), 32'(empty), 32'(vec[i].emp));
            check($sformatf("v%0d_full", i), 32'(full), 32'(vec[i].ful));
            check($sformatf("v%0d_ae", i), 32'(almost_empty), 32'(vec[i].ae));
            check($sformatf("v%0d_af", i), 32'(almost_full), 32'(vec[i].af));
            check($sformatf("v%0d_dout", i), 32'(data_out), 32'(vec[i].dout));
            check($sformatf("v%0d_rv", i), 32'(rd_valid), 32'(vec[i].rv));
            check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vec[i].ovf));
            check($sformatf("v%0d_udf", i), 32'(underflow), 32'(vec[i].udf));
        end

        // Write 0x11..0x1F then read back in order.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(8'h11 + i));
            check("fill15_count", 32'(count), 32'(i + 1));
        end
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
            check("rd15_dout", 32'(data_out), 32'(8'h11 + i));
            check("rd15_rv", 32'(rd_valid), 32'd1);
            check("rd15_count", 32'(count), 32'(14 - i));
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        check("rd15_rv_end", 32'(rd_valid), 32'd0);
        check("rd15_empty", 32'(empty), 32'd1);

        // Fill to full, reject a 17th write, drain the original 16.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
            exp_q.push_back(8'(8'h40 + i));
            check("fill16_af", 32'(almost_full), 32'(i + 1 >= 14));
            check("fill16_full", 32'(full), 32'(i + 1 == 16));
        end
        check("fill16_count", 32'(count), 32'd16);
        check("ovf_before", 32'(overflow), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'hEE);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
            exp_v = exp_q.pop_front();
            check("drain16_dout", 32'(data_out), 32'(exp_v));
        end
        check("drain16_empty", 32'(empty), 32'd1);
        check("ovf_sticky", 32'(overflow), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        check("clr_ovf", 32'(overflow), 32'd0);

        // Full streaming: rd+wr for 40 cycles across several wraps.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(i * 7 + 3));
            exp_q.push_back(8'(i * 7 + 3));
        end
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'(8'h80 + i));
            exp_q.push_back(8'(8'h80 + i));
            exp_v = exp_q.pop_front();
            check("stream_dout", 32'(data_out), 32'(exp_v));
            check("stream_rv", 32'(rd_valid), 32'd1);
            check("stream_full", 32'(full), 32'd1);
            check("stream_count", 32'(count), 32'd16);
            check("stream_ovf", 32'(overflow), 32'd0);
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
            exp_v = exp_q.pop_front();
            check("stream_drain", 32'(data_out), 32'(exp_v));
        end
        check("stream_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-occupancy, away from the clock edge.
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("pre_arst_count", 32'(count), 32'd6);
        #2 rst = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_dout", 32'(data_out), 32'd0);
        check("arst_rv", 32'(rd_valid), 32'd0);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_arst_empty", 32'(empty), 32'd1);
        check("post_arst_count", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. Successor to the fixed 8-bit, 4-entry FIFO, generalised in data width and depth. Adds an occupancy count, programmable almost-full/almost-empty flags, a read-valid strobe, sticky overflow/underflow error flags, and a synchronous flush. Sits between producer and consumer blocks in the same clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
ADDR_W, $clog2(DEPTH), storage index width (derived; do not override)
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
wr  input  1  write request
data_in  input  WIDTH  write data, sampled when the write is accepted
rd  input  1  read request
data_out  output  WIDTH  registered read data
rd_valid  output  1  one-cycle pulse: data_out updated by the previous cycle's accepted read
clear  input  1  synchronous flush
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected

Behaviour:
- Storage: DEPTH x WIDTH register array. wr_ptr and rd_ptr are ADDR_W+1 bits wide; the low ADDR_W bits index storage and the MSB is the wrap bit. All pointer arithmetic is modulo 2^(ADDR_W+1).
- count = wr_ptr - rd_ptr (ADDR_W+1 bits). full, empty, almost_full, almost_empty and count are combinational from the pointers.
- Reset (rst low, asynchronous): pointers = 0, data_out = 0, rd_valid = 0, overflow = 0, underflow = 0. Storage contents are not reset. Outputs after reset: empty = 1, full = 0, count = 0, almost_empty = 1, almost_full = 0. Assertion mid-transfer aborts the transfer; no partial state survives.
- Read acceptance: rd_acc = rd & !empty.
- Write acceptance: wr_acc = wr & (!full | rd_acc). A write while full is accepted only when a read is accepted in the same cycle.
- Accepted write: mem[wr_ptr] <= data_in; wr_ptr increments.
- Accepted read: data_out <= mem[rd_ptr] (old contents, even if the same slot is written that cycle); rd_ptr increments; rd_valid = 1 on the next cycle. Read latency is 1 clock.
- Rejected read: data_out holds its value; rd_valid = 0.
- Simultaneous rd_acc and wr_acc: count is unchanged.
- Empty + rd + wr: the write is accepted, the read is rejected, underflow is set, count becomes 1. There is no fall-through.
- Full + rd + wr: both are accepted; count stays DEPTH; overflow is not set.
- Error flags: overflow <= 1 when wr & !wr_acc; underflow <= 1 when rd & empty. Both stay set until reset or clear.
- clear (synchronous, priority over rd/wr): pointers = 0, overflow = 0, underflow = 0, rd_valid = 0 next cycle. data_out holds. Reads and writes presented in the clear cycle are discarded.
- Wrap-around: pointers roll past DEPTH-1 with the MSB toggling. full and empty stay correct across unlimited wraps.

Test Plan:
- Reset, then write 0x11..0x1F (15 words, WIDTH 8, DEPTH 16), then read 15 -> data_out returns 0x11..0x1F in order, each one cycle after rd, with rd_valid pulsing; count goes 15 -> 0; empty = 1 at the end.
- Write 16 words -> full = 1, count = 16, almost_full asserted from count 14. A 17th write (rd = 0) -> rejected, overflow = 1, contents unchanged; draining returns the original 16 words.
- While empty, assert rd alone -> underflow = 1, data_out holds, rd_valid = 0. Then rd + wr with data_in = 0xA5 -> count = 1, underflow stays 1; the next read returns 0xA5.
- Fill to full, then rd + wr every cycle for 40 cycles -> full stays 1, count = 16, no overflow; the output stream is exactly the input stream delayed by 16 words across multiple pointer wraps.
- Load 5 words, pulse clear together with wr -> count = 0, empty = 1, flags cleared, the clear-cycle write is discarded. Next write 0x3C, then read -> 0x3C.
- Load 7 words, drop rst asynchronously (not clock-aligned) -> outputs reach reset values immediately; after release, empty = 1 and count = 0.
